dllp_replay_ctrl: RTL and testbench
===================================

DLLP_REPLAY_CTRL -- requirements
Module: dllp_replay_ctrl

Interface
REQ-001 SHALL have parameter SEQ_WIDTH, default 12: TLP sequence number width, arithmetic modulo 2^SEQ_WIDTH.
REQ-002 SHALL have parameter INDEX_WIDTH, default 8: retry-buffer slot index width.
REQ-003 SHALL have parameter DEPTH, default 16 (power of 2): maximum outstanding unacknowledged TLPs.
REQ-004 SHALL have parameter REPLAY_TIMEOUT, default 711: replay timer limit in clk_i cycles.
REQ-005 SHALL use one clock; reset is asynchronous and active-low.
REQ-006 SHALL have port clk_i, input, 1: sole clock, rising edge.
REQ-007 SHALL have port rst_n_i, input, 1: asynchronous active-low reset.
REQ-008 SHALL have port tlp_sent_i, input, 1: single-cycle pulse, new TLP fully transmitted.
REQ-009 SHALL have port tlp_seq_i, input, SEQ_WIDTH: sequence number of that TLP.
REQ-010 SHALL have port tlp_index_i, input, INDEX_WIDTH: retry-buffer slot holding that TLP.
REQ-011 SHALL have port ack_valid_i, input, 1: received Ack/Nak DLLP strobe.
REQ-012 SHALL have port ack_nak_i, input, 1: 0 = Ack, 1 = Nak.
REQ-013 SHALL have port ack_seq_i, input, SEQ_WIDTH: AckNak_Seq_Num.
REQ-014 SHALL have port retry_available_o, output, 1: replay request toward the TLP-to-DLLP framer.
REQ-015 SHALL have port retry_index_o, output, INDEX_WIDTH: slot to replay.
REQ-016 SHALL have port retry_done_i, input, 1: pulse, replay of requested slot finished.
REQ-017 SHALL have port tx_hold_o, output, 1: block new TLPs (replaying or full).
REQ-018 SHALL have port retrain_req_o, output, 1: one-cycle link-retrain request.
REQ-019 SHALL have port err_bad_ack_o, output, 1: one-cycle pulse, out-of-range Ack/Nak.
REQ-020 SHALL have port err_overflow_o, output, 1: sticky, tlp_sent_i while tx_hold_o was high.

Function
REQ-021 SHALL hold outstanding (seq, index) pairs in a DEPTH-entry circular FIFO, oldest at head; count 0..DEPTH.
REQ-022 tlp_sent_i with tx_hold_o low SHALL push the entry; with tx_hold_o high the entry SHALL be dropped and err_overflow_o set.
REQ-023 Ack/Nak in range SHALL mean count>0 and (ack_seq_i - head_seq) mod 2^SEQ_WIDTH < count; it SHALL purge head entries through ack_seq_i inclusive.
REQ-024 Nak with ack_seq_i = head_seq - 1 (mod) SHALL be legal, purge nothing, and still trigger replay.
REQ-025 Out-of-range Ack/Nak SHALL be ignored except for a one-cycle err_bad_ack_o pulse.
REQ-026 Same-cycle push and purge SHALL both apply; count updates by +1 minus purged.
REQ-027 Replay timer SHALL count only in IDLE with count>0; cleared on any purging Ack, on entering REPLAY, and when count becomes 0.
REQ-028 FSM states: IDLE, REPLAY_REQ, REPLAY_WAIT.
REQ-029 IDLE -> REPLAY_REQ on legal Nak or timer = REPLAY_TIMEOUT (only when count>0); replay pointer := head after purge.
REQ-030 REPLAY_REQ: retry_available_o=1, retry_index_o = slot at pointer; next cycle -> REPLAY_WAIT.
REQ-031 REPLAY_WAIT: on retry_done_i advance pointer; if pointer reaches tail -> IDLE, else -> REPLAY_REQ.
REQ-032 Ack/Nak during replay SHALL purge but not restart replay; purge past pointer SHALL move pointer to new head; count 0 -> IDLE.
REQ-033 2-bit replay_num SHALL increment on each IDLE->REPLAY_REQ; cleared by any purging Ack.
REQ-034 Replay start with replay_num = 3 SHALL pulse retrain_req_o, set replay_num to 0, and still replay.
REQ-035 tx_hold_o SHALL equal (state != IDLE) or (count = DEPTH), registered-state based, no combinational path from inputs.

Reset
REQ-036 Reset SHALL give state IDLE, FIFO empty, timer 0, replay_num 0, all outputs 0; reset mid-replay SHALL abandon replay with no further retry_available_o.

Structure
REQ-037 Shared package SHALL hold the FSM state enum, SEQ_WIDTH default and REPLAY_TIMEOUT default.
REQ-038 One sub-module, replay_fifo (circular (seq, index) store with head/tail/count and multi-entry purge), SHALL be instantiated.

Verification
REQ-039 Push seq 0..3 (idx 10..13), Ack seq 1 -> count 2, head seq 2, no replay.
REQ-040 Push seq 0..2, Nak seq 0 -> purge 1, retry_index_o 11 then 12 with retry_done_i handshakes, back to IDLE, tx_hold_o high throughout replay.
REQ-041 Push 1 TLP, no Ack for 711 cycles -> retry_available_o at cycle 711; fourth consecutive timeout -> retrain_req_o pulse.
REQ-042 Push seq 4094, 4095, 0; Ack seq 0 -> count 0 (wrap); Ack seq 5 afterwards -> err_bad_ack_o.
REQ-043 Fill 16 entries -> tx_hold_o=1; extra tlp_sent_i -> err_overflow_o=1, count stays 16.
REQ-044 Assert rst_n_i in REPLAY_WAIT -> all outputs 0 asynchronously, IDLE after release.

Source files
------------

// File: rtl/dllp_replay_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// dllp_replay_ctrl_pkg
// Shared definitions for the data-link-layer replay controller:
//   - replay_state_e     : replay FSM states
//   - SEQ_WIDTH_DEF      : default TLP sequence-number width (modulo 2^W)
//   - REPLAY_TIMEOUT_DEF : default replay timer limit in clock cycles
// -----------------------------------------------------------------------------
package dllp_replay_ctrl_pkg;

    localparam int SEQ_WIDTH_DEF      = 12;
    localparam int REPLAY_TIMEOUT_DEF = 711;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_REPLAY_REQ  = 2'd1,
        ST_REPLAY_WAIT = 2'd2
    } replay_state_e;

endpackage

// File: rtl/dllp_replay_ctrl_replay_fifo.sv
// -----------------------------------------------------------------------------
// replay_fifo
// Circular store of outstanding (sequence number, retry-buffer slot) pairs,
// oldest entry at the head. One push per cycle at the tail and a purge of any
// number of head entries in the same cycle.
//
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_push           append (i_push_seq, i_push_index) at the tail
//   i_purge_cnt      number of head entries to drop this cycle (<= o_count)
//   i_rd_off         read offset from the head for o_rd_index
//   o_head_seq       sequence number of the oldest entry (valid when o_count>0)
//   o_rd_index       slot index of the entry at head + i_rd_off
//   o_count          number of stored entries, 0..DEPTH
//   o_full           o_count == DEPTH
// The caller must not push while full nor purge more than o_count entries.
// -----------------------------------------------------------------------------
module replay_fifo #(
    parameter int SEQ_WIDTH   = 12,
    parameter int INDEX_WIDTH = 8,
    parameter int DEPTH       = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_push,
    input  logic [SEQ_WIDTH-1:0]       i_push_seq,
    input  logic [INDEX_WIDTH-1:0]     i_push_index,
    input  logic [$clog2(DEPTH):0]     i_purge_cnt,
    input  logic [$clog2(DEPTH)-1:0]   i_rd_off,
    output logic [SEQ_WIDTH-1:0]       o_head_seq,
    output logic [INDEX_WIDTH-1:0]     o_rd_index,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [SEQ_WIDTH-1:0]   r_seq_mem [DEPTH];
    logic [INDEX_WIDTH-1:0] r_idx_mem [DEPTH];
    logic [AW-1:0]          r_head;
    logic [AW-1:0]          r_tail;
    logic [CNT_W-1:0]       r_count;
    logic [AW-1:0]          w_rd_ptr;

    // NOTE: the storage arrays have no reset; an entry is only ever read at an
    // offset below r_count, so it is always written before it is observed.
    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_seq_mem[r_tail] <= i_push_seq;
            r_idx_mem[r_tail] <= i_push_index;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // updates from the values present before the clock edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            // DEPTH is a power of two, so truncating a purge of DEPTH entries
            // to AW bits wraps the head pointer correctly.
            r_head  <= r_head + AW'(i_purge_cnt);
            r_tail  <= r_tail + AW'(i_push);
            r_count <= r_count + CNT_W'(i_push) - i_purge_cnt;
        end
    end

    assign w_rd_ptr   = r_head + i_rd_off;
    assign o_head_seq = r_seq_mem[r_head];
    assign o_rd_index = r_idx_mem[w_rd_ptr];
    assign o_count    = r_count;
    assign o_full     = (r_count == CNT_W'(DEPTH));

endmodule

// File: rtl/dllp_replay_ctrl.sv
// -----------------------------------------------------------------------------
// dllp_replay_ctrl
// Transmit-side replay controller of a PCIe-style data link layer. Tracks
// unacknowledged TLPs, purges them on Ack/Nak, and drives replay requests to
// the framer on a Nak or a replay-timer expiry. Four consecutive replays
// without forward progress raise a link-retrain request.
//
// Ports:
//   clk_i, rst_n_i       clock (rising edge), asynchronous active-low reset
//   tlp_sent_i           pulse: TLP (tlp_seq_i, tlp_index_i) fully transmitted
//   ack_valid_i          Ack/Nak DLLP strobe; ack_nak_i 0=Ack 1=Nak; ack_seq_i
//   retry_available_o    replay request, slot in retry_index_o
//   retry_done_i         pulse: replay of the requested slot finished
//   tx_hold_o            block new TLPs (replaying or buffer full)
//   retrain_req_o        one-cycle link-retrain request
//   err_bad_ack_o        one-cycle pulse on an out-of-range Ack/Nak
//   err_overflow_o       sticky: a TLP was sent while tx_hold_o was high
// -----------------------------------------------------------------------------
module dllp_replay_ctrl
    import dllp_replay_ctrl_pkg::*;
#(
    parameter int SEQ_WIDTH      = SEQ_WIDTH_DEF,
    parameter int INDEX_WIDTH    = 8,
    parameter int DEPTH          = 16,
    parameter int REPLAY_TIMEOUT = REPLAY_TIMEOUT_DEF
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   tlp_sent_i,
    input  logic [SEQ_WIDTH-1:0]   tlp_seq_i,
    input  logic [INDEX_WIDTH-1:0] tlp_index_i,
    input  logic                   ack_valid_i,
    input  logic                   ack_nak_i,
    input  logic [SEQ_WIDTH-1:0]   ack_seq_i,
    output logic                   retry_available_o,
    output logic [INDEX_WIDTH-1:0] retry_index_o,
    input  logic                   retry_done_i,
    output logic                   tx_hold_o,
    output logic                   retrain_req_o,
    output logic                   err_bad_ack_o,
    output logic                   err_overflow_o
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;
    localparam int TMR_W = $clog2(REPLAY_TIMEOUT + 1);

    replay_state_e          r_state;
    replay_state_e          w_state_next;
    logic [CNT_W-1:0]       r_rp_off;       // replay pointer as offset from head
    logic [TMR_W-1:0]       r_timer;
    logic [1:0]             r_replay_num;
    logic                   r_retrain;
    logic                   r_bad_ack;
    logic                   r_overflow;

    logic [SEQ_WIDTH-1:0]   w_head_seq;
    logic [INDEX_WIDTH-1:0] w_rd_index;
    logic [CNT_W-1:0]       w_count;
    logic                   w_fifo_full;
    logic                   w_tx_hold;
    logic                   w_push;
    logic [SEQ_WIDTH-1:0]   w_ack_dist;
    logic                   w_count_nz;
    logic                   w_in_range;
    logic                   w_nak_prev;
    logic                   w_legal_nak;
    logic                   w_bad_ack;
    logic [CNT_W-1:0]       w_purge_cnt;
    logic [CNT_W-1:0]       w_count_next;
    logic                   w_timer_expire;
    logic                   w_start;
    logic                   w_done_step;
    logic [CNT_W-1:0]       w_adv_off;
    logic [CNT_W-1:0]       w_off_purged;
    logic [1:0]             w_num_base;

    replay_fifo #(
        .SEQ_WIDTH   (SEQ_WIDTH),
        .INDEX_WIDTH (INDEX_WIDTH),
        .DEPTH       (DEPTH)
    ) u_replay_fifo (
        .i_clk        (clk_i),
        .i_rst_n      (rst_n_i),
        .i_push       (w_push),
        .i_push_seq   (tlp_seq_i),
        .i_push_index (tlp_index_i),
        .i_purge_cnt  (w_purge_cnt),
        .i_rd_off     (AW'(r_rp_off)),
        .o_head_seq   (w_head_seq),
        .o_rd_index   (w_rd_index),
        .o_count      (w_count),
        .o_full       (w_fifo_full)
    );

    // Hold depends on registered state only, so it has no input-to-output path.
    assign w_tx_hold = (r_state != ST_IDLE) || w_fifo_full;
    assign w_push    = tlp_sent_i && !w_tx_hold;

    // Ack/Nak classification: distance of AckNak_Seq_Num from the oldest
    // outstanding TLP, modulo 2^SEQ_WIDTH. A Nak naming head-1 acknowledges
    // nothing new but is still a legal replay trigger.
    assign w_ack_dist   = ack_seq_i - w_head_seq;
    assign w_count_nz   = (w_count != '0);
    assign w_in_range   = ack_valid_i && w_count_nz && (w_ack_dist < SEQ_WIDTH'(w_count));
    assign w_nak_prev   = ack_valid_i && ack_nak_i && w_count_nz && (w_ack_dist == '1);
    assign w_legal_nak  = ack_nak_i && (w_in_range || w_nak_prev);
    assign w_bad_ack    = ack_valid_i && !w_in_range && !w_nak_prev;
    assign w_purge_cnt  = w_in_range ? (CNT_W'(w_ack_dist) + CNT_W'(1)) : '0;
    assign w_count_next = w_count + CNT_W'(w_push) - w_purge_cnt;

    // Expiry fires on the edge where the timer would reach REPLAY_TIMEOUT.
    // Forward progress (a purging Ack/Nak) in the same cycle wins.
    assign w_timer_expire = (r_state == ST_IDLE) && w_count_nz &&
                            (r_timer == TMR_W'(REPLAY_TIMEOUT - 1));
    assign w_start        = (r_state == ST_IDLE) &&
                            (w_legal_nak || (w_timer_expire && !w_in_range)) &&
                            (w_count_next != '0);

    // Replay pointer bookkeeping: advance on retry_done_i, then rebase to the
    // new head; entries purged from under the pointer snap it to the head.
    assign w_done_step  = (r_state == ST_REPLAY_WAIT) && retry_done_i;
    assign w_adv_off    = r_rp_off + CNT_W'(w_done_step);
    assign w_off_purged = (w_adv_off >= w_purge_cnt) ? (w_adv_off - w_purge_cnt) : '0;

    // A purging Ack/Nak restarts the consecutive-replay count before a replay
    // it triggers is counted.
    assign w_num_base = w_in_range ? 2'd0 : r_replay_num;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    // NOTE: every signal written in an always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_next = ST_REPLAY_REQ;
                end
            end
            ST_REPLAY_REQ: begin
                w_state_next = (w_count_next == '0) ? ST_IDLE : ST_REPLAY_WAIT;
            end
            ST_REPLAY_WAIT: begin
                if (w_count_next == '0) begin
                    w_state_next = ST_IDLE;
                end else if (w_done_step) begin
                    w_state_next = (w_off_purged == w_count_next) ? ST_IDLE : ST_REPLAY_REQ;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        retry_available_o = 1'b0;
        retry_index_o     = '0;
        if (r_state == ST_REPLAY_REQ) begin
            retry_available_o = 1'b1;
            retry_index_o     = w_rd_index;
        end
    end

    assign tx_hold_o      = w_tx_hold;
    assign retrain_req_o  = r_retrain;
    assign err_bad_ack_o  = r_bad_ack;
    assign err_overflow_o = r_overflow;

    // ---------------- Replay datapath ----------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_rp_off     <= '0;
            r_timer      <= '0;
            r_replay_num <= '0;
            r_retrain    <= 1'b0;
            r_bad_ack    <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_bad_ack  <= w_bad_ack;
            r_overflow <= r_overflow || (tlp_sent_i && w_tx_hold);
            r_retrain  <= w_start && (w_num_base == 2'd3);

            r_rp_off <= (r_state == ST_IDLE) ? '0 : w_off_purged;

            if (w_start) begin
                r_replay_num <= (w_num_base == 2'd3) ? 2'd0 : (w_num_base + 2'd1);
            end else if (w_in_range) begin
                r_replay_num <= 2'd0;
            end

            if ((r_state != ST_IDLE) || w_start || w_in_range || (w_count_next == '0)) begin
                r_timer <= '0;
            end else if (w_count_nz) begin
                r_timer <= r_timer + TMR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_dllp_replay_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dllp_replay_ctrl
// Self-checking bench: a queue-based reference model of the replay rules is
// advanced on every clock edge and compared against the DUT outputs on every
// falling edge; directed scenarios add hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_dllp_replay_ctrl;

    localparam int SEQ_WIDTH   = 12;
    localparam int INDEX_WIDTH = 8;
    localparam int DEPTH       = 16;
    localparam int TIMEOUT     = 711;
    localparam int SEQ_MOD     = 1 << SEQ_WIDTH;

    typedef struct {
        int seq;
        int idx;
    } entry_t;

    logic                   clk_i = 1'b0;
    logic                   rst_n_i = 1'b1;
    logic                   tlp_sent_i = 1'b0;
    logic [SEQ_WIDTH-1:0]   tlp_seq_i = '0;
    logic [INDEX_WIDTH-1:0] tlp_index_i = '0;
    logic                   ack_valid_i = 1'b0;
    logic                   ack_nak_i = 1'b0;
    logic [SEQ_WIDTH-1:0]   ack_seq_i = '0;
    logic                   retry_available_o;
    logic [INDEX_WIDTH-1:0] retry_index_o;
    logic                   retry_done_i = 1'b0;
    logic                   tx_hold_o;
    logic                   retrain_req_o;
    logic                   err_bad_ack_o;
    logic                   err_overflow_o;

    int n_tests = 0;
    int n_fail  = 0;

    dllp_replay_ctrl dut (
        .clk_i             (clk_i),
        .rst_n_i           (rst_n_i),
        .tlp_sent_i        (tlp_sent_i),
        .tlp_seq_i         (tlp_seq_i),
        .tlp_index_i       (tlp_index_i),
        .ack_valid_i       (ack_valid_i),
        .ack_nak_i         (ack_nak_i),
        .ack_seq_i         (ack_seq_i),
        .retry_available_o (retry_available_o),
        .retry_index_o     (retry_index_o),
        .retry_done_i      (retry_done_i),
        .tx_hold_o         (tx_hold_o),
        .retrain_req_o     (retrain_req_o),
        .err_bad_ack_o     (err_bad_ack_o),
        .err_overflow_o    (err_overflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- Reference model ----------------
    entry_t m_q[$];
    bit     m_busy    = 0;   // a replay is in progress
    bit     m_req     = 0;   // a replay request is being presented this cycle
    int     m_pos     = 0;   // replay position, counted from the oldest entry
    int     m_age     = 0;   // idle cycles with outstanding TLPs since last clear
    int     m_num     = 0;   // consecutive replays without forward progress
    bit     m_retrain = 0;
    bit     m_bad     = 0;
    bit     m_ovf     = 0;

    task automatic model_reset();
        m_q.delete();
        m_busy = 0; m_req = 0; m_pos = 0; m_age = 0; m_num = 0;
        m_retrain = 0; m_bad = 0; m_ovf = 0;
    endtask

    task automatic model_step();
        int  n0;
        int  d;
        int  purged;
        bit  held;
        bit  legal;
        bit  expired;
        bit  start;
        bit  was_busy;
        bit  advanced;
        entry_t e;
        n0       = m_q.size();
        held     = m_busy || (n0 == DEPTH);
        purged   = 0;
        legal    = 0;
        start    = 0;
        advanced = 0;
        was_busy = m_busy;
        expired  = !m_busy && (n0 > 0) && (m_age == TIMEOUT - 1);
        m_retrain = 0;
        m_bad     = 0;

        if (tlp_sent_i && held) m_ovf = 1;

        if (ack_valid_i) begin
            if (n0 > 0) begin
                d = (int'(ack_seq_i) - m_q[0].seq + SEQ_MOD) % SEQ_MOD;
                if (d < n0) begin
                    legal  = 1;
                    purged = d + 1;
                end else if (ack_nak_i && d == SEQ_MOD - 1) begin
                    legal = 1;
                end
            end
            if (!legal) m_bad = 1;
        end

        repeat (purged) void'(m_q.pop_front());
        if (tlp_sent_i && !held) begin
            e.seq = int'(tlp_seq_i);
            e.idx = int'(tlp_index_i);
            m_q.push_back(e);
        end
        if (purged > 0) m_num = 0;

        if (m_busy) begin
            if (m_req) begin
                m_req = 0;
            end else if (retry_done_i) begin
                m_pos++;
                advanced = 1;
            end
            m_pos = (m_pos >= purged) ? m_pos - purged : 0;
            if (m_q.size() == 0) begin
                m_busy = 0;
                m_req  = 0;
            end else if (advanced) begin
                if (m_pos == m_q.size()) m_busy = 0;
                else m_req = 1;
            end
        end else begin
            start = ((legal && ack_nak_i) || (expired && purged == 0)) && (m_q.size() > 0);
            if (start) begin
                m_busy = 1;
                m_req  = 1;
                m_pos  = 0;
                if (m_num == 3) begin
                    m_retrain = 1;
                    m_num     = 0;
                end else begin
                    m_num++;
                end
            end
        end

        if (was_busy || start || purged > 0 || m_q.size() == 0) m_age = 0;
        else if (n0 > 0) m_age++;
    endtask

    always @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) model_reset();
        else model_step();
    end

    function automatic int exp_index();
        if (m_busy && m_req && m_pos < m_q.size()) return m_q[m_pos].idx;
        return 0;
    endfunction

    // ---------------- Cycle-by-cycle comparison ----------------
    always @(negedge clk_i) begin
        check("retry_available", 32'(retry_available_o), 32'(m_busy && m_req));
        check("retry_index",     32'(retry_index_o),     32'(exp_index()));
        check("tx_hold",         32'(tx_hold_o),         32'(m_busy || m_q.size() == DEPTH));
        check("retrain_req",     32'(retrain_req_o),     32'(m_retrain));
        check("err_bad_ack",     32'(err_bad_ack_o),     32'(m_bad));
        check("err_overflow",    32'(err_overflow_o),    32'(m_ovf));
    end

    // ---------------- Stimulus helpers ----------------
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        tlp_sent_i   = 1'b0;
        ack_valid_i  = 1'b0;
        ack_nak_i    = 1'b0;
        retry_done_i = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n_i = 1'b0;
        tick();
        tick();
        rst_n_i = 1'b1;
    endtask

    task automatic send(input int seq, input int idx);
        tlp_sent_i  = 1'b1;
        tlp_seq_i   = SEQ_WIDTH'(seq);
        tlp_index_i = INDEX_WIDTH'(idx);
        tick();
        tlp_sent_i  = 1'b0;
    endtask

    task automatic ack(input bit nak, input int seq);
        ack_valid_i = 1'b1;
        ack_nak_i   = nak;
        ack_seq_i   = SEQ_WIDTH'(seq);
        tick();
        ack_valid_i = 1'b0;
        ack_nak_i   = 1'b0;
    endtask

    // Accept the currently presented replay request and finish it.
    task automatic service_one();
        tick();
        retry_done_i = 1'b1;
        tick();
        retry_done_i = 1'b0;
    endtask

    task automatic wait_avail(input int max_cyc, output int cyc);
        cyc = 0;
        while (!retry_available_o && cyc < max_cyc) begin
            tick();
            cyc++;
        end
    endtask

    initial begin
        #200000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- Main sequence ----------------
    initial begin
        int cyc;
        int drv_seq;
        #1;
        do_reset();
        check("reset_hold", 32'(tx_hold_o), 32'd0);
        check("reset_avail", 32'(retry_available_o), 32'd0);

        // Ack in the middle of the outstanding window.
        for (int i = 0; i < 4; i++) send(i, 10 + i);
        ack(1'b0, 1);
        check("ack_count", 32'(m_q.size()), 32'd2);
        check("ack_head_seq", 32'(m_q[0].seq), 32'd2);
        check("ack_no_replay", 32'(retry_available_o), 32'd0);
        repeat (3) tick();
        check("ack_no_replay_later", 32'(retry_available_o), 32'd0);

        // Nak: purge the head, replay the remaining two slots.
        do_reset();
        for (int i = 0; i < 3; i++) send(i, 10 + i);
        ack(1'b1, 0);
        check("nak_first_avail", 32'(retry_available_o), 32'd1);
        check("nak_first_index", 32'(retry_index_o), 32'd11);
        check("nak_hold_req", 32'(tx_hold_o), 32'd1);
        service_one();
        check("nak_second_avail", 32'(retry_available_o), 32'd1);
        check("nak_second_index", 32'(retry_index_o), 32'd12);
        check("nak_hold_req2", 32'(tx_hold_o), 32'd1);
        service_one();
        check("nak_done_avail", 32'(retry_available_o), 32'd0);
        check("nak_done_hold", 32'(tx_hold_o), 32'd0);

        // Replay timer; the fourth consecutive timeout requests retraining.
        do_reset();
        send(0, 5);
        for (int r = 1; r <= 4; r++) begin
            wait_avail(800, cyc);
            check("timeout_cycles", 32'(cyc), 32'd711);
            check("timeout_retrain", 32'(retrain_req_o), 32'(r == 4));
            check("timeout_index", 32'(retry_index_o), 32'd5);
            service_one();
        end

        // Sequence-number wrap and an out-of-range Ack.
        do_reset();
        send(4094, 1);
        send(4095, 2);
        send(0, 3);
        ack(1'b0, 0);
        check("wrap_count", 32'(m_q.size()), 32'd0);
        check("wrap_no_bad", 32'(err_bad_ack_o), 32'd0);
        ack(1'b0, 5);
        check("bad_ack_pulse", 32'(err_bad_ack_o), 32'd1);
        tick();
        check("bad_ack_one_cycle", 32'(err_bad_ack_o), 32'd0);

        // Fill to DEPTH, then overflow.
        do_reset();
        for (int i = 0; i < DEPTH; i++) send(i, i);
        check("full_hold", 32'(tx_hold_o), 32'd1);
        check("full_no_ovf", 32'(err_overflow_o), 32'd0);
        send(DEPTH, DEPTH);
        check("overflow_set", 32'(err_overflow_o), 32'd1);
        check("overflow_count", 32'(m_q.size()), 32'd16);
        ack(1'b0, DEPTH - 1);
        check("drained_hold", 32'(tx_hold_o), 32'd0);
        check("overflow_sticky", 32'(err_overflow_o), 32'd1);

        // Reset while waiting for a replay to finish.
        do_reset();
        send(0, 1);
        send(1, 2);
        ack(1'b1, 0);
        tick();
        check("wait_hold", 32'(tx_hold_o), 32'd1);
        #2 rst_n_i = 1'b0;
        #1;
        check("async_rst_hold", 32'(tx_hold_o), 32'd0);
        check("async_rst_avail", 32'(retry_available_o), 32'd0);
        check("async_rst_index", 32'(retry_index_o), 32'd0);
        tick();
        rst_n_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("post_rst_no_replay", 32'(retry_available_o), 32'd0);
        end

        // Randomized traffic against the model.
        drv_seq = 4090;
        for (int c = 0; c < 3000; c++) begin
            int k;
            int aseq;
            idle_inputs();
            if ($urandom_range(0, 99) < 35 && (!tx_hold_o || $urandom_range(0, 19) == 0)) begin
                tlp_sent_i  = 1'b1;
                tlp_seq_i   = SEQ_WIDTH'(drv_seq);
                tlp_index_i = INDEX_WIDTH'($urandom_range(0, 255));
                if (!tx_hold_o) drv_seq = (drv_seq + 1) % SEQ_MOD;
            end
            if ($urandom_range(0, 99) < 15) begin
                k = $urandom_range(0, 9);
                if (m_q.size() > 0 && k < 7) aseq = m_q[0].seq + int'($urandom_range(0, m_q.size() - 1));
                else if (m_q.size() > 0 && k == 7) aseq = m_q[0].seq - 1;
                else aseq = int'($urandom_range(0, SEQ_MOD - 1));
                ack_valid_i = 1'b1;
                ack_nak_i   = ($urandom_range(0, 3) == 0);
                ack_seq_i   = SEQ_WIDTH'(aseq);
            end
            retry_done_i = ($urandom_range(0, 2) == 0);
            tick();
        end
        idle_inputs();
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
